// File: rtl/fp_add_result_queue.sv
// rtl/fp_add_result_queue.sv - FIFO for recoded-float adder results with tag and sticky exception flags
module fp_add_result_queue #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 24,
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 4,
  localparam int DATA_W   = EXP_WIDTH + SIG_WIDTH + 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [4:0]        in_flags,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_flags,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flags_clr,
  output logic [4:0]        sticky_flags,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic [4:0]        mem_flags  [DEPTH];
  logic [TAG_W-1:0]  mem_tag    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Ready/valid come from occupancy only, so there is no combinational path from out_ready to in_ready.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = mem_result[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= '0;
        mem_tag[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= in_result;
        mem_flags[wr_ptr]  <= in_flags;
        mem_tag[wr_ptr]    <= in_tag;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // A clear wipes history only; flags of an entry accepted in the same cycle survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
    end else if (flags_clr) begin
      sticky_flags <= push ? in_flags : 5'b0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

endmodule

// File: tb/tb_fp_add_result_queue.sv
// tb/tb_fp_add_result_queue.sv - directed self-checking bench for fp_add_result_queue
module tb_fp_add_result_queue;

  localparam int DATA_W = 33;
  localparam int TAG_W  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [4:0]        in_flags;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic              flags_clr;
  logic [4:0]        sticky_flags;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  fp_add_result_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_tag = '0;
    out_ready = 1'b0; flags_clr = 1'b0;
    #3;
    chk("reset_count", count, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_sticky", sticky_flags, 0);
    chk("reset_out_result", out_result, 0);
    #10 rst_n = 1'b1;
    tick();

    // Single push of recoded 2.0, no same-cycle bypass
    in_valid = 1'b1; in_result = 33'h0_8080_0000; in_flags = 5'b0; in_tag = 4'd3;
    #1 chk("no_bypass_out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", out_valid, 1);
    chk("single_out_result", out_result, 33'h0_8080_0000);
    chk("single_out_tag", out_tag, 3);
    chk("single_count", count, 1);
    chk("single_sticky", sticky_flags, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", count, 0);
    chk("single_pop_out_valid", out_valid, 0);

    // Fill to full under backpressure
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_tag = TAG_W'(i); in_result = DATA_W'(33'h1_0000_0000 + i);
      tick();
    end
    in_tag = 4'd4; in_result = 33'h1_0000_0004;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_reject_count", count, 4);
    chk("full_head_tag", out_tag, 0);
    chk("full_head_result", out_result, 33'h1_0000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_count", count, 3);
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_head_tag", out_tag, 1);
    tick();
    in_valid = 1'b0;
    chk("tag4_accept_count", count, 4);
    out_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      chk($sformatf("drain_tag_%0d", t), out_tag, 64'(t));
      chk($sformatf("drain_result_%0d", t), out_result, 64'(33'h1_0000_0000 + t));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", count, 0);

    // Continuous streaming with pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_tag = TAG_W'(k); in_result = DATA_W'(33'h0_0111_0000 * (k + 1));
      tick();
      chk($sformatf("stream_count_%0d", k), count, 1);
      chk($sformatf("stream_tag_%0d", k), out_tag, 64'(k));
      chk($sformatf("stream_result_%0d", k), out_result, 64'(33'h0_0111_0000 * (k + 1)));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end_count", count, 0);

    // Sticky flag accumulation and clear
    in_valid = 1'b1; in_tag = 4'd1; in_flags = 5'b00001;
    tick();
    in_tag = 4'd2; in_flags = 5'b10000;
    tick();
    in_valid = 1'b0;
    chk("sticky_or", sticky_flags, 5'b10001);
    chk("head_flags", out_flags, 5'b00001);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("sticky_clr", sticky_flags, 0);
    chk("head_flags_after_clr", out_flags, 5'b00001);
    flags_clr = 1'b1; in_valid = 1'b1; in_tag = 4'd3; in_flags = 5'b00100;
    tick();
    flags_clr = 1'b0; in_valid = 1'b0;
    chk("sticky_clr_push", sticky_flags, 5'b00100);
    chk("pre_reset_count", count, 3);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_count", count, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_sticky", sticky_flags, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_out_valid", out_valid, 0);
    in_valid = 1'b1; in_tag = 4'd9; in_result = 33'h1_2345_6789; in_flags = 5'b00010;
    tick();
    in_valid = 1'b0;
    chk("post_reset_count", count, 1);
    chk("post_reset_tag", out_tag, 9);
    chk("post_reset_result", out_result, 33'h1_2345_6789);
    chk("post_reset_flags", out_flags, 5'b00010);
    chk("post_reset_sticky", sticky_flags, 5'b00010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_reset_drain_count", count, 0);
    chk("post_reset_no_stale", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_result_queue.md
Name: fp_add_result_queue

Overview:
- Downstream stage of the recoded-float adder (addRecFN). Captures each adder result with its 5-bit exception flags and a request tag into a small FIFO.
- Presents entries to the writeback consumer over a valid/ready handshake.
- Keeps a sticky, software-clearable OR of all accepted exception flags (fflags-style accumulator).
- Decouples adder issue from writeback stalls.

Parameters:
- EXP_WIDTH, 8, adder exponent width; the recoded exponent is EXP_WIDTH+1 bits.
- SIG_WIDTH, 24, significand width including the hidden bit.
- TAG_W, 4, width of the request tag carried alongside each result.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- Derived: DATA_W = EXP_WIDTH+SIG_WIDTH+1 (33 at defaults); CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  adder result available.
- in_ready  out  1  queue can accept an entry.
- in_result  in  DATA_W  recoded adder output.
- in_flags  in  5  adder exceptionFlags {invalid, infinite, overflow, underflow, inexact}.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head.
- out_result  out  DATA_W  head result.
- out_flags  out  5  head flags.
- out_tag  out  TAG_W  head tag.
- flags_clr  in  1  clear the sticky flags.
- sticky_flags  out  5  accumulated OR of accepted flags.
- count  out  CNT_W  current occupancy.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (on rst_n low, asynchronous):
  - count=0, out_valid=0, in_ready=1, sticky_flags=0.
  - Read and write pointers = 0; out_result/out_flags/out_tag = 0.
  - Mid-operation reset discards all entries; no partial entry survives.
- Handshake and ready/valid:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It is registered-state only and never depends on out_ready in the same cycle (no full-bypass).
  - out_valid = (count != 0). Outputs are driven from the head storage entry.
- Latency and ordering:
  - An entry pushed in cycle N is visible at the outputs in cycle N+1. There is no same-cycle bypass, even when empty.
  - Entries leave in strict FIFO order; result, flags and tag stay bound together.
- Holding under backpressure:
  - While out_valid=1 and out_ready=0, out_result/out_flags/out_tag are held stable.
  - in_valid while in_ready=0 is ignored; the upstream holds its data.
- Pointers and occupancy:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count: +1 on push only, -1 on pop only, unchanged on push&pop.
- Boundary conditions:
  - Push&pop when empty is impossible (no out_valid). Push when empty sets count=1.
  - Push&pop in the same cycle at count=k (0<k<DEPTH): count stays k, head advances, new tail entry is written.
  - Full (count=DEPTH): in_ready=0; a pop frees a slot and in_ready=1 on the next cycle.
- Sticky flags:
  - On push, sticky_flags <= sticky_flags | in_flags.
  - flags_clr alone: sticky_flags <= 0.
  - flags_clr and push in the same cycle: sticky_flags <= in_flags. The clear applies to prior history; the new entry's flags are kept.
  - Flags are accumulated at acceptance, not at pop.
- Flag pass-through: out_flags are per-entry copies and unaffected by flags_clr.
- Data handling: no arithmetic on result data; the DATA_W bits pass through unmodified.

Test Plan:
- Reset then single push:
  - Stimulus: in_result=33'h0_8080_0000 (recoded 2.0), in_flags=0, in_tag=3, out_ready=0.
  - Response: out_valid=1 next cycle with identical data, count=1, sticky=0. Asserting out_ready for one cycle pops it: count=0, out_valid=0.
- Fill to full with out_ready=0:
  - Stimulus: push tags 0..3, then hold in_valid with tag 4.
  - Response: in_ready=0 at count=4 and tag 4 is not accepted. One pop yields tag 0; in_ready=1 next cycle, tag 4 is accepted, and later drain order is 1,2,3,4.
- Continuous streaming:
  - Stimulus: in_valid=1 and out_ready=1 every cycle for 10 pushes of tags 0..9.
  - Response: count settles at 1, every tag is observed exactly once in order, and the pointers wrap twice without loss.
- Sticky flags:
  - Stimulus: push flags 5'b00001 then 5'b10000.
  - Response: sticky=5'b10001. flags_clr alone gives 0. flags_clr together with a push of 5'b00100 gives 5'b00100.
- Reset mid-operation:
  - Stimulus: with count=3 and sticky nonzero, pulse rst_n low asynchronously between clock edges.
  - Response: count=0, out_valid=0, in_ready=1, sticky=0 immediately. After reset release, the next push is returned correctly and no stale entry appears.
